// File: rtl/branch_predict_unit.sv
// Direct-mapped branch target buffer with 2-bit direction counters, a zero-latency
// combinational lookup port, a single resolve/update port and saturating statistics.
module branch_predict_unit #(
  parameter int ENTRIES = 16,
  parameter int AW      = 32,
  parameter int CW      = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic [AW-1:0] lk_pc,
  output logic          lk_taken,
  output logic [AW-1:0] lk_target,
  input  logic          upd_valid,
  input  logic [AW-1:0] upd_pc,
  input  logic          upd_taken,
  input  logic [AW-1:0] upd_target,
  input  logic          upd_pred_taken,
  input  logic [AW-1:0] upd_pred_target,
  output logic          mispredict,
  output logic [CW-1:0] br_cnt,
  output logic [CW-1:0] miss_cnt
);

  localparam int IW = $clog2(ENTRIES);
  localparam int TW = AW - IW - 2;

  // Control state (reset) and payload state (never reset) kept in separate arrays.
  logic [ENTRIES-1:0] valid_q;
  logic [1:0]         ctr_q [ENTRIES];
  logic [TW-1:0]      tag_q [ENTRIES];
  logic [AW-1:0]      tgt_q [ENTRIES];

  logic [IW-1:0] lk_idx;
  logic [TW-1:0] lk_tag;
  logic          lk_hit;
  logic [IW-1:0] upd_idx;
  logic [TW-1:0] upd_tag;
  logic          upd_hit;
  logic          ent_we;
  logic          alloc;
  logic          train;
  logic          unused_pc_lsb;

  function automatic logic [1:0] ctr_next(input logic [1:0] ctr, input logic taken);
    if (taken) return (ctr == 2'b11) ? 2'b11 : ctr + 2'b01;
    else       return (ctr == 2'b00) ? 2'b00 : ctr - 2'b01;
  endfunction

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (&v) ? v : v + CW'(1);
  endfunction

  // Lookup: purely combinational, reads pre-update contents.
  assign lk_idx    = lk_pc[IW+1:2];
  assign lk_tag    = lk_pc[AW-1:IW+2];
  assign lk_hit    = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
  assign lk_taken  = lk_hit && ctr_q[lk_idx][1];
  assign lk_target = lk_taken ? tgt_q[lk_idx] : lk_pc + AW'(4);

  // Resolve side: hit detection and write qualification.
  assign upd_idx       = upd_pc[IW+1:2];
  assign upd_tag       = upd_pc[AW-1:IW+2];
  assign upd_hit       = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);
  assign unused_pc_lsb = ^upd_pc[1:0];

  assign mispredict = upd_valid &&
                      ((upd_taken != upd_pred_taken) ||
                       (upd_taken && upd_pred_taken && (upd_target != upd_pred_target)));

  // clr and rst both suppress any entry write in the same cycle.
  assign ent_we = upd_valid && !clr && !rst;
  assign alloc  = ent_we && !upd_hit && upd_taken;
  assign train  = ent_we && upd_hit;

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      for (int i = 0; i < ENTRIES; i++) ctr_q[i] <= 2'b00;
    end else if (clr) begin
      valid_q <= '0;
    end else if (alloc) begin
      valid_q[upd_idx] <= 1'b1;
      ctr_q[upd_idx]   <= 2'b10;
    end else if (train) begin
      ctr_q[upd_idx] <= ctr_next(ctr_q[upd_idx], upd_taken);
    end
  end

  always_ff @(posedge clk) begin
    if (alloc) tag_q[upd_idx] <= upd_tag;
    if (ent_we && upd_taken) tgt_q[upd_idx] <= upd_target;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      br_cnt   <= '0;
      miss_cnt <= '0;
    end else if (upd_valid) begin
      br_cnt <= sat_inc(br_cnt);
      if (mispredict) miss_cnt <= sat_inc(miss_cnt);
    end
  end

endmodule
